// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds issued ops until both operands are valid, wakes them from the
// CDB and dispatches the oldest ready entry. Define RS_CDB_BYPASS_EN for zero-latency CDB wake-up.
module reservation_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [2:0]       issue_unit,
    input  logic [9:0]       issue_op,
    input  logic [31:0]      issue_pc_plus4,
    input  logic [31:0]      issue_rdm,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             issue_qj_busy,
    input  logic             issue_qk_busy,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,

    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,

    output logic             disp_valid,
    input  logic             disp_ready,
    output logic [2:0]       disp_unit,
    output logic [9:0]       disp_op,
    output logic [31:0]      disp_pc_plus4,
    output logic [31:0]      disp_rdm,
    output logic [31:0]      disp_vj,
    output logic [31:0]      disp_vk,
    output logic [TAG_W-1:0] disp_tag
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] qj_busy_q, qj_busy_d;
    logic [DEPTH-1:0] qk_busy_q, qk_busy_d;
    logic [2:0]       unit_q [DEPTH];
    logic [2:0]       unit_d [DEPTH];
    logic [9:0]       op_q   [DEPTH];
    logic [9:0]       op_d   [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [31:0]      rdm_q  [DEPTH];
    logic [31:0]      rdm_d  [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [TAG_W-1:0] tag_d  [DEPTH];
    logic [TAG_W-1:0] qj_q   [DEPTH];
    logic [TAG_W-1:0] qj_d   [DEPTH];
    logic [TAG_W-1:0] qk_q   [DEPTH];
    logic [TAG_W-1:0] qk_d   [DEPTH];
    logic [31:0]      vj_q   [DEPTH];
    logic [31:0]      vj_d   [DEPTH];
    logic [31:0]      vk_q   [DEPTH];
    logic [31:0]      vk_d   [DEPTH];
    // older_q[a][b] set means entry a was issued before entry b
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    logic [DEPTH-1:0] cdb_hit_j, cdb_hit_k;
    logic [DEPTH-1:0] ready, sel_oh;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             issue_fire, disp_fire;
    logic             issue_cap_j, issue_cap_k;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cdb_hit_j[i] = cdb_valid && busy_q[i] && qj_busy_q[i] && (qj_q[i] == cdb_tag);
            cdb_hit_k[i] = cdb_valid && busy_q[i] && qk_busy_q[i] && (qk_q[i] == cdb_tag);
`ifdef RS_CDB_BYPASS_EN
            ready[i] = busy_q[i] && (!qj_busy_q[i] || cdb_hit_j[i])
                                 && (!qk_busy_q[i] || cdb_hit_k[i]);
`else
            ready[i] = busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i];
`endif
        end
    end

    // An entry is selected when no other ready entry is older than it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && older_q[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
    end

    assign disp_valid = |ready;

    always_comb begin
        disp_unit     = '0;
        disp_op       = '0;
        disp_pc_plus4 = '0;
        disp_rdm      = '0;
        disp_vj       = '0;
        disp_vk       = '0;
        disp_tag      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                disp_unit     = unit_q[i];
                disp_op       = op_q[i];
                disp_pc_plus4 = pc_q[i];
                disp_rdm      = rdm_q[i];
                disp_tag      = tag_q[i];
`ifdef RS_CDB_BYPASS_EN
                disp_vj       = cdb_hit_j[i] ? cdb_value : vj_q[i];
                disp_vk       = cdb_hit_k[i] ? cdb_value : vk_q[i];
`else
                disp_vj       = vj_q[i];
                disp_vk       = vk_q[i];
`endif
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_ready = ~&busy_q;
    assign issue_fire  = issue_valid && issue_ready && !flush;
    assign disp_fire   = disp_valid && disp_ready;
    assign issue_cap_j = issue_qj_busy && cdb_valid && (issue_qj == cdb_tag);
    assign issue_cap_k = issue_qk_busy && cdb_valid && (issue_qk == cdb_tag);

    always_comb begin
        busy_d    = busy_q;
        qj_busy_d = qj_busy_q;
        qk_busy_d = qk_busy_q;
        unit_d    = unit_q;
        op_d      = op_q;
        pc_d      = pc_q;
        rdm_d     = rdm_q;
        tag_d     = tag_q;
        qj_d      = qj_q;
        qk_d      = qk_q;
        vj_d      = vj_q;
        vk_d      = vk_q;
        older_d   = older_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_hit_j[i]) begin
                qj_busy_d[i] = 1'b0;
                vj_d[i]      = cdb_value;
            end
            if (cdb_hit_k[i]) begin
                qk_busy_d[i] = 1'b0;
                vk_d[i]      = cdb_value;
            end
            if (disp_fire && sel_oh[i]) begin
                busy_d[i] = 1'b0;
            end
        end

        if (issue_fire) begin
            busy_d[free_idx]    = 1'b1;
            unit_d[free_idx]    = issue_unit;
            op_d[free_idx]      = issue_op;
            pc_d[free_idx]      = issue_pc_plus4;
            rdm_d[free_idx]     = issue_rdm;
            tag_d[free_idx]     = issue_tag;
            qj_d[free_idx]      = issue_qj;
            qk_d[free_idx]      = issue_qk;
            qj_busy_d[free_idx] = issue_qj_busy && !issue_cap_j;
            qk_busy_d[free_idx] = issue_qk_busy && !issue_cap_k;
            vj_d[free_idx]      = issue_cap_j ? cdb_value :
                                  (issue_qj_busy ? '0 : issue_vj);
            vk_d[free_idx]      = issue_cap_k ? cdb_value :
                                  (issue_qk_busy ? '0 : issue_vk);
            // Newest entry: younger than every other slot.
            older_d[free_idx] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (IDX_W'(j) != free_idx) begin
                    older_d[j][free_idx] = 1'b1;
                end
            end
        end

        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            qj_busy_q <= '0;
            qk_busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                unit_q[i]  <= '0;
                op_q[i]    <= '0;
                pc_q[i]    <= '0;
                rdm_q[i]   <= '0;
                tag_q[i]   <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                older_q[i] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            qj_busy_q <= qj_busy_d;
            qk_busy_q <= qk_busy_d;
            unit_q    <= unit_d;
            op_q      <= op_d;
            pc_q      <= pc_d;
            rdm_q     <= rdm_d;
            tag_q     <= tag_d;
            qj_q      <= qj_d;
            qk_q      <= qk_d;
            vj_q      <= vj_d;
            vk_q      <= vk_d;
            older_q   <= older_d;
        end
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Tomasulo reservation station that feeds the execute stage: holds issued instructions until both source operands are valid, then dispatches Unit/Op/pc_plus4/Vj/Vk/rdm plus a destination tag.
- Missing operands are captured by snooping the common data bus (CDB), which carries execute results back.
- Sits between rename/issue and the execute stage; it is the operand-producing end of the execute interface.

Parameters:
DEPTH, 4, number of entries (power of two, 2..16)
TAG_W, 4, width of ROB/destination tags

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  mispredict flush; discards every entry
issue_valid  in  1  issue request
issue_ready  out  1  at least one free entry
issue_unit  in  3  functional unit code (ALU/BRANCH/MUL/DIV/LOAD encoding)
issue_op  in  10  operation code
issue_pc_plus4  in  32  pc+4 of instruction
issue_rdm  in  32  load data / passthrough operand
issue_tag  in  TAG_W  destination tag
issue_qj_busy, issue_qk_busy  in  1 each  operand j/k still pending
issue_qj, issue_qk  in  TAG_W each  producer tags when busy
issue_vj, issue_vk  in  32 each  operand values when not busy
cdb_valid  in  1  CDB broadcast this cycle
cdb_tag  in  TAG_W  broadcast tag
cdb_value  in  32  broadcast value
disp_valid  out  1  an entry is dispatching
disp_ready  in  1  execute stage accepts
disp_unit  out  3; disp_op  out  10; disp_pc_plus4, disp_rdm, disp_vj, disp_vk  out  32 each; disp_tag  out  TAG_W

Behaviour:
- Reset (async, rst_n=0): all entry busy bits 0; issue_ready=1; disp_valid=0; all disp_* data outputs 0.
- Entry state: busy, unit, op, pc_plus4, rdm, tag, qj_busy/qj/vj, qk_busy/qk/vk.
- Issue: when issue_valid & issue_ready, the lowest-indexed free entry is written at the clock edge. issue_ready = (count of busy entries < DEPTH); a same-cycle dispatch does not raise issue_ready.
- Issue-time CDB capture: if issue_qj_busy and cdb_valid and cdb_tag==issue_qj, the entry is written with qj_busy=0 and vj=cdb_value. The same rule applies to k. No operand is lost to a simultaneous broadcast.
- Wake-up: every cycle, each busy entry with qX_busy and qX==cdb_tag (cdb_valid=1) captures cdb_value into vX and clears qX_busy at the edge. Both operands may wake in the same cycle.
- Ready: entry is busy & !qj_busy & !qk_busy.
- Selection: oldest ready entry, tracked by an issue-order age matrix. Ties are impossible.
- disp_valid = any ready entry; disp_* are driven combinationally from the selected entry. When disp_valid=0, disp_* are 0.
- Handshake: when disp_valid & disp_ready, the selected entry's busy bit clears at the edge. If disp_ready=0, the selection may change only when an older entry becomes ready.
- Wake-up to dispatch latency: 1 cycle (entry captured at edge N is dispatch-eligible in cycle N+1).
- Issue to dispatch with both operands valid: 1 cycle.
- flush: all busy bits clear at the edge. Flush has priority over a same-cycle issue, which is dropped, and over dispatch bookkeeping. disp_valid is still combinational during the flush cycle and must be ignored downstream.
- Full: issue_valid while issue_ready=0 has no effect.
- Empty: disp_valid=0.
- Reset mid-operation: all entries are discarded immediately.

Optional Feature:
- RS_CDB_BYPASS_EN defined: an entry whose only missing operand(s) match the current cdb_tag counts as ready this cycle. disp_vj/disp_vk are muxed from cdb_value, so wake-up to dispatch latency is 0.
- RS_CDB_BYPASS_EN undefined: latency is 1 as above.
- Issue and age ordering are unchanged either way.

Test Plan:
- Reset, then issue ALU op 0x001 with vj=5, vk=7, tag=3, disp_ready=1 -> next cycle disp_valid=1, disp_vj=5, disp_vk=7, disp_tag=3; the cycle after, disp_valid=0.
- Issue with qj_busy, qj=9; then CDB tag=9, value=0x1234 -> disp_vj=0x1234 one cycle after the broadcast (same cycle with RS_CDB_BYPASS_EN).
- Issue with qk=2 in the same cycle as CDB tag=2, value=0xAA -> entry stores vk=0xAA and dispatches the next cycle.
- Fill 4 entries all waiting on tag 1 -> issue_ready=0 and a fifth issue is ignored. Broadcast tag 1 with disp_ready=1 -> entries dispatch in issue order, one per cycle.
- Hold disp_ready=0 with 2 ready entries for 3 cycles -> disp_tag is stable on the oldest entry and no entry is freed.
- flush with 3 busy entries plus a concurrent issue -> next cycle disp_valid=0, issue_ready=1, all entries empty.
